cordic_phase_gen: RTL and testbench

Phase-sweep generator that sits directly upstream of `cordic_engine`. It produces a stream of Q2.21 angles, always wrapped into [-π, π), from a configured start phase, step and sample count. One accepted configuration produces one burst, and each angle carries a one-cycle valid strobe that drives `angle_in`/`input_valid`. Because the output is always range-reduced, the CORDIC core never sees angles outside its convergence range.

---
 rtl/cordic_phase_gen.sv | 211 +++++++++++++++++++++
 tb/tb_cordic_phase_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen
// ----------------
// Phase-sweep generator feeding cordic_engine. One accepted configuration
// produces one burst of cfg_count angles. The burst starts at cfg_start and
// advances by cfg_step. Every emitted angle is wrapped into [-PI_Q, PI_Q),
// so the CORDIC core only ever sees angles inside its convergence range.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   cfg_valid    configuration offered
//   cfg_ready    block idle, configuration accepted on cfg_valid && cfg_ready
//   cfg_start    start phase, signed Q2.21 (any value, reduced internally)
//   cfg_step     phase increment, signed Q2.21 (any value, reduced internally)
//   cfg_count    number of samples in the burst (0 allowed)
//   en           sample enable, one sample per enabled cycle
//   abort        synchronous burst cancel (wins over en)
//   angle_out    phase sample, signed Q2.21 in [-PI_Q, PI_Q)
//   angle_valid  angle_out valid this cycle
//   busy         burst in progress (state not IDLE)
//   done         one-cycle pulse at the end of a completed burst

module cordic_phase_gen #(
    parameter int W        = 24,
    parameter int FRAC     = 21,
    parameter int PI_Q     = 6588397,
    parameter int TWO_PI_Q = 13176794,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [W-1:0]     cfg_start,
    input  logic [W-1:0]     cfg_step,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             en,
    input  logic             abort,
    output logic [W-1:0]     angle_out,
    output logic             angle_valid,
    output logic             busy,
    output logic             done
);

    // Angles are widened by one integer bit (Q3.21) so that the sum of two
    // in-range angles, or an unreduced start value, cannot overflow before
    // the wrap correction is applied.
    localparam int INT_W = W - FRAC;
    typedef logic signed [INT_W+FRAC:0] ext_t;

    localparam ext_t PI_E     = ext_t'(PI_Q);
    localparam ext_t NEG_PI_E = -ext_t'(PI_Q);
    localparam ext_t TWO_PI_E = ext_t'(TWO_PI_Q);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Single-step range reduction into [-PI, PI). Every caller passes a value
    // within one turn of that interval, so one correction is enough.
    function automatic ext_t wrap_q(input ext_t x);
        ext_t r;
        if (x >= PI_E) begin
            r = x - TWO_PI_E;
        end else if (x < NEG_PI_E) begin
            r = x + TWO_PI_E;
        end else begin
            r = x;
        end
        return r;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [W-1:0]     acc_r;
    logic [W-1:0]     step_r;
    logic [CNT_W-1:0] rem_r;
    logic [W-1:0]     angle_out_r;
    logic             angle_valid_r;
    logic             busy_r;
    logic             done_r;
    ext_t             ext_acc_s;
    ext_t             ext_step_s;
    ext_t             sum_s;

    // Sign-extended operands and the unreduced next accumulator value.
    always_comb begin
        ext_acc_s  = {acc_r[W-1], acc_r};
        ext_step_s = {step_r[W-1], step_r};
        sum_s      = ext_acc_s + ext_step_s;
    end

    // Next-state decode. abort only cancels LOAD and RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_valid) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (rem_r != CNT_ZERO) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (en && (rem_r == CNT_ONE)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: capture on transfer, reduce in LOAD, step and emit in RUN.
    // The raw start value is parked in acc_r and the count in rem_r until
    // LOAD, so no separate capture registers are needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r         <= {W{1'b0}};
            step_r        <= {W{1'b0}};
            rem_r         <= {CNT_W{1'b0}};
            angle_out_r   <= {W{1'b0}};
            angle_valid_r <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            angle_valid_r <= 1'b0;
            done_r        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        acc_r  <= cfg_start;
                        step_r <= cfg_step;
                        rem_r  <= cfg_count;
                    end else begin
                        acc_r  <= acc_r;
                    end
                end
                ST_LOAD: begin
                    acc_r  <= W'(wrap_q(ext_acc_s));
                    step_r <= W'(wrap_q(ext_step_s));
                end
                ST_RUN: begin
                    if (abort) begin
                        angle_valid_r <= 1'b0;
                    end else if (en) begin
                        angle_out_r   <= acc_r;
                        angle_valid_r <= 1'b1;
                        acc_r         <= W'(wrap_q(sum_s));
                        rem_r         <= rem_r - CNT_ONE;
                    end else begin
                        angle_valid_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered busy flag, tracks the state the FSM is entering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
        end
    end

    assign cfg_ready   = (state_r == ST_IDLE);
    assign angle_out   = angle_out_r;
    assign angle_valid = angle_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed testbench for cordic_phase_gen. Outputs are observed on the
// falling clock edge; every expectation is a hand-computed constant.

module tb_cordic_phase_gen;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [23:0] cfg_start;
    logic [23:0] cfg_step;
    logic [15:0] cfg_count;
    logic        en;
    logic        abort;
    logic [23:0] angle_out;
    logic        angle_valid;
    logic        busy;
    logic        done;

    cordic_phase_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_start   (cfg_start),
        .cfg_step    (cfg_step),
        .cfg_count   (cfg_count),
        .en          (en),
        .abort       (abort),
        .angle_out   (angle_out),
        .angle_valid (angle_valid),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;
    int done_n   = 0;
    int done_cyc = -1;
    bit pi_seen  = 1'b0;
    logic signed [23:0] samp_q[$];
    int vcyc_q[$];
    int xfer_q[$];

    // Edge counter: after active edge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Record configuration transfers by the edge number they occur on.
    always @(posedge clk) begin
        if (rst_n && cfg_valid && cfg_ready) xfer_q.push_back(cyc + 1);
    end

    // Collect emitted samples and done pulses away from the active edge.
    always @(negedge clk) begin
        if (angle_valid) begin
            samp_q.push_back($signed(angle_out));
            vcyc_q.push_back(cyc);
            if ($signed(angle_out) == 24'sd6588397) pi_seen = 1'b1;
        end
        if (done) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        samp_q.delete();
        vcyc_q.delete();
        done_n   = 0;
        done_cyc = -1;
        pi_seen  = 1'b0;
    endtask

    // Offer one configuration; returns just after the transfer edge (t0).
    task automatic start_burst(input int s, input int st, input int c);
        @(negedge clk);
        check_val("cfg_ready_before_xfer", cfg_ready, 1);
        clear_log();
        cfg_start = s[23:0];
        cfg_step  = st[23:0];
        cfg_count = c[15:0];
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        cfg_valid = 1'b0;
    endtask

    task automatic check_samples(input string tag, input int n,
                                 input int v0, input int v1, input int v2);
        check_val({tag, "_count"}, samp_q.size(), n);
        if (samp_q.size() >= 3) begin
            check_val({tag, "_s0"}, samp_q[0], v0);
            check_val({tag, "_s1"}, samp_q[1], v1);
            check_val({tag, "_s2"}, samp_q[2], v2);
        end
    endtask

    int exp_sweep[10] = '{0, 1647099, 3294198, 4941297, 6588396,
                          -4941299, -3294200, -1647101, -2, 1647097};
    int en_pat[7]     = '{1, 0, 0, 1, 1, 0, 1};
    int gate_cyc[4]   = '{2, 5, 6, 8};

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_start = 24'd0;
        cfg_step  = 24'd0;
        cfg_count = 16'd0;
        en        = 1'b1;
        abort     = 1'b0;

        repeat (2) @(negedge clk);
        check_val("rst_angle_out", angle_out, 0);
        check_val("rst_angle_valid", angle_valid, 0);
        check_val("rst_done", done, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_cfg_ready", cfg_ready, 1);
        rst_n = 1'b1;

        // Basic pi/4 sweep with a wrap at sample 6.
        start_burst(0, 1647099, 10);
        repeat (15) @(negedge clk);
        check_val("sweep_count", samp_q.size(), 10);
        for (int i = 0; i < 10 && i < samp_q.size(); i++) begin
            check_val($sformatf("sweep_s%0d", i), samp_q[i], exp_sweep[i]);
            check_val($sformatf("sweep_c%0d", i), vcyc_q[i] - t0, 2 + i);
        end
        check_val("sweep_done_n", done_n, 1);
        check_val("sweep_done_cyc", done_cyc - t0, 12);

        // Start phase reduction from both sides.
        start_burst(8386510, 0, 3);
        repeat (7) @(negedge clk);
        check_samples("redpos", 3, -4790284, -4790284, -4790284);
        start_burst(-8386510, 0, 3);
        repeat (7) @(negedge clk);
        check_samples("redneg", 3, 4790284, 4790284, 4790284);

        // -PI is legal, one step below wraps to just under +PI.
        start_burst(-6588397, -1, 3);
        repeat (7) @(negedge clk);
        check_samples("negwrap", 3, -6588397, 6588396, 6588395);
        check_val("negwrap_no_pi", pi_seen, 0);

        // Enable gating: samples only on enabled RUN edges, output holds.
        start_burst(0, 1000, 4);
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 2) begin
                check_val("gate_hold_out", angle_out, 0);
                check_val("gate_hold_valid", angle_valid, 0);
            end
            en = en_pat[k][0];
        end
        repeat (4) @(negedge clk);
        en = 1'b1;
        check_samples("gate", 4, 0, 1000, 2000);
        if (samp_q.size() == 4) check_val("gate_s3", samp_q[3], 3000);
        for (int i = 0; i < 4 && i < vcyc_q.size(); i++)
            check_val($sformatf("gate_c%0d", i), vcyc_q[i] - t0, gate_cyc[i]);
        check_val("gate_done_cyc", done_cyc - t0, 9);

        // Zero count: no samples, done two edges after transfer.
        start_burst(123, 5, 0);
        repeat (5) @(negedge clk);
        check_val("zero_count", samp_q.size(), 0);
        check_val("zero_done_n", done_n, 1);
        check_val("zero_done_cyc", done_cyc - t0, 2);

        // cfg_valid held high through a burst: next transfer only at N+3.
        @(negedge clk);
        clear_log();
        xfer_q.delete();
        cfg_start = 24'd100;
        cfg_step  = 24'd10;
        cfg_count = 16'd5;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        cfg_start = 24'd5000;
        cfg_step  = 24'd0;
        cfg_count = 16'd2;
        repeat (10) @(negedge clk);
        cfg_valid = 1'b0;
        repeat (6) @(negedge clk);
        check_val("block_xfers", xfer_q.size(), 2);
        if (xfer_q.size() >= 2) check_val("block_period", xfer_q[1] - xfer_q[0], 8);
        check_val("block_count", samp_q.size(), 7);
        if (samp_q.size() == 7) begin
            check_val("block_s1", samp_q[1], 110);
            check_val("block_s4", samp_q[4], 140);
            check_val("block_s5", samp_q[5], 5000);
        end

        // Abort after the third sample.
        start_burst(0, 1000, 8);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("abort_valid", angle_valid, 0);
        check_val("abort_ready", cfg_ready, 1);
        check_val("abort_busy", busy, 0);
        repeat (4) @(negedge clk);
        check_samples("abort", 3, 0, 1000, 2000);
        check_val("abort_no_done", done_n, 0);

        // Asynchronous reset mid-burst, then a fresh burst.
        start_burst(0, 1000, 8);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_angle_out", angle_out, 0);
        check_val("arst_angle_valid", angle_valid, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("arst_no_done", done_n, 0);
        start_burst(777, 1, 2);
        repeat (6) @(negedge clk);
        check_samples("arst_new", 2, 777, 778, 0);
        if (samp_q.size() == 2) begin
            check_val("arst_new_s0", samp_q[0], 777);
            check_val("arst_new_s1", samp_q[1], 778);
        end
        check_val("arst_new_done", done_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
